cpu_trace_buffer: RTL
=====================

# cpu_trace_buffer

Hardware instruction-trace capture for the 8080 system: on every M1 strobe it records a CPU state snapshot ({f, a, hl, sp, pc} packed into `DATA_W` bits) into a circular buffer of `DEPTH` entries. It arms on command, triggers on a masked PC match or a forced trigger, keeps a programmable number of post-trigger samples, then freezes and streams the window out oldest-first over a valid/ready port. It sits beside the `i8080` core in `invaders` and replaces simulation-only `$display` tracing with a synthesizable, depth- and trigger-configurable capture.

## Interface
- `DATA_W`, 64, snapshot width; bits [15:0] are the PC field used for trigger compare (must be ≥16)
- `DEPTH`, 256, buffer entries; power of two, ≥4
- `ADDR_W`, $clog2(DEPTH), pointer width (derived)

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `arm`  in  1  pulse: start capture (honoured only in IDLE)
- `sample_en`  in  1  M1 strobe: capture `sample_data` this cycle
- `sample_data`  in  DATA_W  snapshot
- `trig_value`  in  16  PC compare value
- `trig_mask`  in  16  1 = bit participates in compare
- `force_trig`  in  1  pulse: trigger unconditionally (ARMED only)
- `post_count`  in  ADDR_W  samples kept after trigger sample; sampled at trigger
- `rd_valid`  out  1  readout entry available
- `rd_data`  out  DATA_W  readout entry
- `rd_last`  out  1  current entry is final entry
- `rd_ready`  in  1  consumer accepts entry
- `state`  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DUMP
- `fill`  out  ADDR_W+1  valid entries, saturates at DEPTH
- `wrapped`  out  1  buffer overwrote an entry since arm
- `trig_index`  out  ADDR_W  readout position of trigger sample (valid in DUMP)

## Operation
- Reset: state=IDLE, `fill`=0, `wrapped`=0, `trig_index`=0, `rd_valid`=0, `rd_last`=0, `rd_data`=0; write/read pointers 0. Buffer contents not cleared. Reset mid-capture or mid-dump aborts immediately.
- IDLE: `sample_en`, `force_trig`, `rd_ready` ignored. `arm` → ARMED; clears pointers, `fill`, `wrapped`.
- ARMED: each `sample_en` writes `buf[wr_ptr]`, `wr_ptr` += 1 mod DEPTH, `fill` += 1 saturating; write while `fill`==DEPTH sets `wrapped`. Trigger = (`sample_en` && ((`sample_data[15:0]` ^ `trig_value`) & `trig_mask`)==0) || `force_trig`. Mask 0 triggers on first sample. On trigger: latch `post_count`; if 0 → DUMP, else → POST with counter = `post_count`.
- `sample_en` and `force_trig` together: sample written and is the trigger sample. `force_trig` alone: no write; trigger sample = none, `trig_index` = `fill`−1 (saturate 0).
- POST: each `sample_en` writes as in ARMED and decrements counter; write that brings counter to 0 → DUMP. Triggers ignored.
- DUMP entry: `trig_index` = `fill` − 1 − latched `post_count`; read pointer = `wrapped` ? `wr_ptr` : 0; remaining = `fill`.
- DUMP: `rd_valid` = remaining≠0; `rd_data` = `buf[rd_ptr]` (async read of current pointer); `rd_last` = remaining==1. Pop on `rd_valid && rd_ready`: `rd_ptr` += 1 mod DEPTH, remaining −= 1. Pop of last entry → IDLE. Entering DUMP with `fill`==0 → IDLE next cycle, `rd_valid` never high. `sample_en` and `arm` ignored in DUMP.
- `rd_valid` never drops without a pop; `rd_data` stable while `rd_valid && !rd_ready`.

## Timing
- Write occurs on the edge where `sample_en`=1; `fill` reflects it next cycle.
- State changes one cycle after the causing edge (trigger sample at edge N → `state`=POST/DUMP after edge N).
- First `rd_valid` the cycle after DUMP entry; sustained throughput one entry per cycle with `rd_ready` held high.
- Total capture latency = sample cycles; no fixed pipeline delay beyond one register stage for state/status.

## Test plan
- DEPTH=8, arm, 3 samples PC=0x0000..0x0002, mask 0xFFFF value 0x0002, post_count=0 → DUMP, `fill`=3, `trig_index`=2, readout 0x0000,0x0001,0x0002 with `rd_last` on third, then IDLE.
- DEPTH=8, arm, 12 samples PC=0x10..0x1B, trigger on 0x18, post_count=3 → `wrapped`=1, `fill`=8, readout 0x14..0x1B oldest-first, `trig_index`=4.
- Mask 0xFF00 value 0x1A00, samples 0x0100, 0x1A37 → trigger on 0x1A37; `force_trig` with `sample_en` PC=0x0005 in ARMED → trigger on that sample.
- Readout with `rd_ready` toggling 1,0,0,1 → `rd_data` held stable during stall, no entry skipped or repeated.
- `rst` asserted in POST after 2 of 5 post samples → next cycle `state`=0, `fill`=0, `rd_valid`=0; subsequent `arm` captures cleanly.
- `force_trig` immediately after `arm` with no samples, post_count=0 → DUMP then IDLE, `rd_valid` never asserted.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular instruction-trace capture for the 8080 core.
// Records one snapshot per M1 strobe, triggers on a masked PC match or a
// forced trigger, keeps a programmable post-trigger tail, then streams the
// frozen window out oldest-first over a valid/ready port.
module cpu_trace_buffer #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [15:0]       trig_value,
  input  logic [15:0]       trig_mask,
  input  logic              force_trig,
  input  logic [ADDR_W-1:0] post_count,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  input  logic              rd_ready,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   fill,
  output logic              wrapped,
  output logic [ADDR_W-1:0] trig_index
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DUMP  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q, post_cnt_q, post_lat_q, trig_index_q;
  logic [ADDR_W:0]   fill_q, remain_q;
  logic              wrapped_q;

  logic              capturing, wr_en, pc_hit, trig, post_done, enter_dump, pop;
  logic [ADDR_W-1:0] wr_ptr_d, dump_post, rd_ptr_d, trig_index_d;
  logic [ADDR_W:0]   fill_d, post_ext;
  logic              wrapped_d;

  // Next-state values for the write side and the DUMP-entry bookkeeping.
  // The DUMP entry values use the post-write fill/pointer so a trigger on a
  // sample (or the last post sample) is counted in the window.
  always_comb begin
    capturing  = (state_q == S_ARMED) || (state_q == S_POST);
    wr_en      = capturing && sample_en;
    wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    fill_d     = (wr_en && (fill_q != FULL)) ? fill_q + 1'b1 : fill_q;
    wrapped_d  = wrapped_q | (wr_en && (fill_q == FULL));
    pc_hit     = sample_en && (((sample_data[15:0] ^ trig_value) & trig_mask) == 16'h0000);
    trig       = (state_q == S_ARMED) && (pc_hit || force_trig);
    post_done  = (state_q == S_POST) && wr_en && (post_cnt_q == ADDR_W'(1));
    enter_dump = (trig && (post_count == '0)) || post_done;
    dump_post  = trig ? post_count : post_lat_q;
    post_ext   = {1'b0, dump_post};
    // Trigger position is fill-1-post, clamped at zero when a forced
    // trigger arrives with fewer samples than the requested tail.
    trig_index_d = (fill_d > post_ext) ? ADDR_W'(fill_d - post_ext - 1'b1) : '0;
    rd_ptr_d   = wrapped_d ? wr_ptr_d : '0;
    pop        = (state_q == S_DUMP) && (remain_q != '0) && rd_ready;
  end

  // Trace storage; deliberately not reset so the last window survives.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr_q] <= sample_data;
    end
  end

  // Capture/readout control FSM with its status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      post_cnt_q   <= '0;
      post_lat_q   <= '0;
      trig_index_q <= '0;
      fill_q       <= '0;
      remain_q     <= '0;
      wrapped_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_q   <= S_ARMED;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            wrapped_q <= 1'b0;
          end
        end
        S_ARMED: begin
          wr_ptr_q  <= wr_ptr_d;
          fill_q    <= fill_d;
          wrapped_q <= wrapped_d;
          if (trig) begin
            post_lat_q <= post_count;
            post_cnt_q <= post_count;
            state_q    <= S_POST;
          end
        end
        S_POST: begin
          wr_ptr_q  <= wr_ptr_d;
          fill_q    <= fill_d;
          wrapped_q <= wrapped_d;
          if (wr_en) begin
            post_cnt_q <= post_cnt_q - 1'b1;
          end
        end
        default: begin
          if (remain_q == '0) begin
            state_q <= S_IDLE;
          end else if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            remain_q <= remain_q - 1'b1;
            if (remain_q == (ADDR_W+1)'(1)) begin
              state_q <= S_IDLE;
            end
          end
        end
      endcase
      // Overrides the ARMED/POST transitions above when the window closes.
      if (enter_dump) begin
        state_q      <= S_DUMP;
        rd_ptr_q     <= rd_ptr_d;
        remain_q     <= fill_d;
        trig_index_q <= trig_index_d;
      end
    end
  end

  assign state      = state_q;
  assign fill       = fill_q;
  assign wrapped    = wrapped_q;
  assign trig_index = trig_index_q;
  assign rd_valid   = (state_q == S_DUMP) && (remain_q != '0);
  assign rd_last    = rd_valid && (remain_q == (ADDR_W+1)'(1));
  assign rd_data    = rd_valid ? mem[rd_ptr_q] : '0;

endmodule
